pipeline_perf_monitor: RTL and testbench
========================================

# pipeline_perf_monitor

Hardware performance monitor for the five-stage pipelined CPU. Sits downstream of the hazard-detection, control and pipeline-register stages and consumes their status strobes. Counts run cycles, load-use stalls, control flushes and (optionally) retired instructions. Freezes itself after a configurable cycle budget and exposes the counts on a registered read port to the host or bench.

## Interface
Parameters:
- CNT_W, 32, width of every counter and of data_o
- MAX_CYCLES, 30, cycle budget; 0 = unlimited

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  run enable from the CPU start line; level-sensitive
- clear_i  in  1  synchronous clear of all counters and state
- bubble_i  in  1  hazard unit bubble request
- jump_i  in  1  control unit jump decode
- branch_i  in  1  control unit taken-branch decode
- flush1_i  in  1  IF/ID flush source 1
- flush2_i  in  1  IF/ID flush source 2
- wb_valid_i  in  1  MEM/WB stage holds a real, non-bubble instruction
- sel_i  in  2  read select: 0 cycles, 1 stalls, 2 flushes, 3 retired
- data_o  out  CNT_W  selected counter, registered
- running_o  out  1  FSM in RUN
- done_o  out  1  FSM in DONE

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN when start_i = 1.
  - RUN→IDLE when start_i = 0; counters hold, resume later.
  - RUN→DONE on the edge where cycle count becomes MAX_CYCLES (only if MAX_CYCLES ≠ 0).
  - DONE is sticky; only clear_i or reset leaves it, both to IDLE.
- Counting happens only in RUN. Each event is sampled on the same edge as the state update.
  - cycles: +1 every RUN cycle.
  - stalls: +1 when bubble_i & ~jump_i & ~branch_i.
  - flushes: +1 when flush1_i | flush2_i. Both asserted counts once.
  - retired: +1 when wb_valid_i.
- All counters saturate at all-ones and never wrap.
- clear_i zeroes every counter and forces IDLE. It has priority over start_i and over the DONE transition in the same cycle.
- In DONE, all event inputs are ignored.
- sel_i = 3 reads 0 when the retired counter is compiled out.

## Timing
- Reset (rst_i low, asynchronous): state IDLE, all counters 0, data_o 0, running_o 0, done_o 0.
- Deassertion of reset is synchronous to clk_i. The first counting edge is the first edge with rst_i high, state RUN.
- Start latency: start_i high before edge N gives state RUN after edge N. Events at edge N+1 are the first counted.
- data_o latency is 1 cycle: it reflects sel_i and the counter values as registered at the previous edge. It never shows a value mid-update.
- running_o and done_o are decoded directly from the state register. They are glitch-free and change only at clock edges or on reset assertion.
- With MAX_CYCLES = 30, the cycle counter reads 30 and done_o rises on the 30th counting edge.
- Reset asserted mid-run discards all counts immediately.

## Configuration
- PERF_RETIRE_EN defined: retired counter and wb_valid_i logic are present.
- PERF_RETIRE_EN undefined:
  - retired counter removed.
  - wb_valid_i unused, port kept.
  - sel_i = 3 returns 0.

## Structure
- Shared package `perf_pkg` holds:
  - FSM state enum (IDLE/RUN/DONE).
  - sel_i encoding constants (SEL_CYCLES, SEL_STALLS, SEL_FLUSHES, SEL_RETIRED).
- One sub-module, `sat_counter`. It is parameterized by width, with inputs clk, rst_n, clr, inc, and output count. It saturates at all-ones.
- The top level instantiates it three or four times, plus the FSM and the read mux register.

## Test plan
- Reset/defaults: hold rst_i low, toggle inputs → data_o = 0 for every sel_i, running_o = 0, done_o = 0.
- Budget stop: MAX_CYCLES = 30, start_i high, no events → after 30 edges cycles = 30 and done_o = 1. Thereafter cycles stays 30 and further events are not counted.
- Stall filtering: 4 cycles of bubble_i = 1, of which 1 has jump_i = 1 and 1 has branch_i = 1 → stalls = 2.
- Dual flush: flush1_i = flush2_i = 1 for 3 cycles, then flush1_i alone for 2 cycles → flushes = 5.
- Pause and clear: run 5 cycles, drop start_i for 4, resume 3 → cycles = 8. Then assert clear_i together with start_i → all counters 0, state IDLE.
- Saturation/retire: CNT_W = 3, MAX_CYCLES = 0, wb_valid_i = 1 for 10 RUN cycles → retired = 7 with PERF_RETIRE_EN defined. Without the macro, sel_i = 3 reads 0.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared types and constants for the pipeline performance monitor.
// Holds the monitor FSM encoding and the read-select encoding used by the host.
package perf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } perf_state_e;

    localparam logic [1:0] SEL_CYCLES  = 2'd0;
    localparam logic [1:0] SEL_STALLS  = 2'd1;
    localparam logic [1:0] SEL_FLUSHES = 2'd2;
    localparam logic [1:0] SEL_RETIRED = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: synchronous clear beats increment, holds at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_perf_monitor.sv
// Performance monitor for the five-stage CPU: counts run cycles, load-use stalls,
// flushes and (with PERF_RETIRE_EN defined) retired instructions, behind a registered read port.
module pipeline_perf_monitor
    import perf_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 30
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic             bubble_i,
    input  logic             jump_i,
    input  logic             branch_i,
    input  logic             flush1_i,
    input  logic             flush2_i,
    input  logic             wb_valid_i,
    input  logic [1:0]       sel_i,
    output logic [CNT_W-1:0] data_o,
    output logic             running_o,
    output logic             done_o
);

    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

    perf_state_e      state_q;
    perf_state_e      state_d;
    logic [CNT_W-1:0] data_q;
    logic [CNT_W-1:0] data_d;

    logic [CNT_W-1:0] cycles_cnt;
    logic [CNT_W-1:0] stalls_cnt;
    logic [CNT_W-1:0] flushes_cnt;
    logic [CNT_W-1:0] retired_cnt;

    logic in_run;
    logic budget_hit;
    logic stall_ev;
    logic flush_ev;

    assign in_run     = (state_q == ST_RUN);
    // The budget edge is the one on which the cycle counter steps onto MAX_CYCLES.
    assign budget_hit = (MAX_CYCLES != 0) && (cycles_cnt == LAST_CYCLE);
    // A bubble coinciding with a jump/branch is a control flush, not a load-use stall.
    assign stall_ev   = in_run & bubble_i & ~jump_i & ~branch_i;
    assign flush_ev   = in_run & (flush1_i | flush2_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (start_i) state_d = ST_RUN;
                ST_RUN: begin
                    if (budget_hit)    state_d = ST_DONE;
                    else if (!start_i) state_d = ST_IDLE;
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        running_o = (state_q == ST_RUN);
        done_o    = (state_q == ST_DONE);
    end

    sat_counter #(.W(CNT_W)) u_cycles (
        .clk(clk_i), .rst_n(rst_i), .clr(clear_i), .inc(in_run), .count(cycles_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stalls (
        .clk(clk_i), .rst_n(rst_i), .clr(clear_i), .inc(stall_ev), .count(stalls_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flushes (
        .clk(clk_i), .rst_n(rst_i), .clr(clear_i), .inc(flush_ev), .count(flushes_cnt)
    );

`ifdef PERF_RETIRE_EN
    sat_counter #(.W(CNT_W)) u_retired (
        .clk(clk_i), .rst_n(rst_i), .clr(clear_i), .inc(in_run & wb_valid_i), .count(retired_cnt)
    );
`else
    logic unused_wb_valid;
    assign unused_wb_valid = wb_valid_i;
    assign retired_cnt     = '0;
`endif

    always_comb begin
        data_d = '0;
        unique case (sel_i)
            SEL_CYCLES:  data_d = cycles_cnt;
            SEL_STALLS:  data_d = stalls_cnt;
            SEL_FLUSHES: data_d = flushes_cnt;
            SEL_RETIRED: data_d = retired_cnt;
            default:     data_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Directed, scoreboard-checked bench for pipeline_perf_monitor (budget instance plus a
// 3-bit unlimited instance for saturation); define PERF_RETIRE_EN to cover the retired counter.
module tb_pipeline_perf_monitor;
    import perf_pkg::*;

    localparam int MAXC = 30;

    typedef enum {M_IDLE, M_RUN, M_DONE} m_state_e;
    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start, clr, bub, jmp, br, f1, f2, wb;
    logic [1:0]  sel;
    logic [31:0] data;
    logic        running, done;

    logic        start2, clr2, wb2;
    logic [1:0]  sel2;
    logic [2:0]  data2;
    logic        running2, done2;

    int          total;
    int          bad;
    exp_t        sb[$];

    m_state_e    m_state;
    int unsigned m_cyc, m_st, m_fl, m_ret;

    pipeline_perf_monitor #(.CNT_W(32), .MAX_CYCLES(MAXC)) u_dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .clear_i(clr),
        .bubble_i(bub), .jump_i(jmp), .branch_i(br), .flush1_i(f1), .flush2_i(f2),
        .wb_valid_i(wb), .sel_i(sel), .data_o(data), .running_o(running), .done_o(done)
    );

    pipeline_perf_monitor #(.CNT_W(3), .MAX_CYCLES(0)) u_sat (
        .clk_i(clk), .rst_i(rst_n), .start_i(start2), .clear_i(clr2),
        .bubble_i(1'b0), .jump_i(1'b0), .branch_i(1'b0), .flush1_i(1'b0), .flush2_i(1'b0),
        .wb_valid_i(wb2), .sel_i(sel2), .data_o(data2), .running_o(running2), .done_o(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input string tag, input logic [31:0] e);
        exp_t it;
        it.tag = tag;
        it.exp = e;
        sb.push_back(it);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t it;
        it = sb.pop_front();
        total++;
        assert (obs === it.exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", it.tag, obs, it.exp);
        end
    endtask

    task automatic check_now(input string tag, input logic [31:0] obs, input logic [31:0] e);
        push_exp(tag, e);
        pop_check(obs);
    endtask

    function automatic logic [31:0] model_val(input logic [1:0] s);
        case (s)
            SEL_CYCLES:  return m_cyc;
            SEL_STALLS:  return m_st;
            SEL_FLUSHES: return m_fl;
            default:     return m_ret;
        endcase
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_cyc = 0; m_st = 0; m_fl = 0; m_ret = 0;
    endtask

    // Apply the reference model for the coming edge, then advance to 1 time unit past it.
    task automatic tick();
        if (clr) begin
            model_reset();
        end else begin
            case (m_state)
                M_IDLE: if (start) m_state = M_RUN;
                M_RUN: begin
                    m_cyc++;
                    if (bub && !jmp && !br) m_st++;
                    if (f1 || f2) m_fl++;
`ifdef PERF_RETIRE_EN
                    if (wb) m_ret++;
`endif
                    if (m_cyc == MAXC) m_state = M_DONE;
                    else if (!start) m_state = M_IDLE;
                end
                default: m_state = M_DONE;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic read(input string tag, input logic [1:0] s);
        push_exp(tag, model_val(s));
        sel = s;
        tick();
        pop_check(data);
    endtask

    task automatic events_off();
        bub = 0; jmp = 0; br = 0; f1 = 0; f2 = 0; wb = 0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_reset();
        rst_n = 1'b0;
        start = 0; clr = 0; sel = 0;
        events_off();
        start2 = 0; clr2 = 0; wb2 = 0; sel2 = 0;

        // Reset held low while inputs toggle: everything must stay at zero.
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            start = 1; bub = 1; f1 = 1; wb = 1; start2 = 1; wb2 = 1;
            @(posedge clk);
            #1;
            check_now($sformatf("rst_data_sel%0d", i), data, 32'd0);
        end
        check_now("rst_running", {31'd0, running}, 32'd0);
        check_now("rst_done", {31'd0, done}, 32'd0);
        start = 0; start2 = 0; wb2 = 0;
        events_off();
        rst_n = 1'b1;
        tick();

        // Stall filtering: four bubbles, one masked by jump and one by branch.
        clr = 1; tick(); clr = 0;
        start = 1; tick();
        check_now("running_in_run", {31'd0, running}, 32'd1);
        bub = 1; jmp = 1; tick();
        jmp = 0; br = 1;  tick();
        br = 0;           tick();
        tick();
        events_off(); start = 0; tick();
        read("stalls", SEL_STALLS);
        check_now("stalls_const", data, 32'd2);

        // Dual flush: both sources together count once.
        clr = 1; tick(); clr = 0;
        start = 1; tick();
        f1 = 1; f2 = 1;
        for (int i = 0; i < 3; i++) tick();
        f2 = 0;
        for (int i = 0; i < 2; i++) tick();
        events_off(); start = 0; tick();
        read("flushes", SEL_FLUSHES);
        check_now("flushes_const", data, 32'd5);

        // Pause and resume: counts hold across IDLE.
        clr = 1; tick(); clr = 0;
        start = 1; tick();
        for (int i = 0; i < 4; i++) tick();
        start = 0;
        for (int i = 0; i < 4; i++) tick();
        start = 1; tick();
        for (int i = 0; i < 2; i++) tick();
        start = 0; tick();
        read("pause_cycles", SEL_CYCLES);
        check_now("pause_cycles_const", data, 32'd8);

        // Clear wins over start in the same cycle.
        clr = 1; start = 1; tick();
        clr = 0; start = 0;
        check_now("clear_running", {31'd0, running}, 32'd0);
        for (int i = 0; i < 4; i++) read($sformatf("clear_sel%0d", i), 2'(i));

        // Budget stop at MAX_CYCLES, then events are ignored in DONE.
        start = 1; tick();
        for (int i = 0; i < MAXC - 1; i++) tick();
        check_now("done_before_budget", {31'd0, done}, {31'd0, m_state == M_DONE});
        tick();
        check_now("done_at_budget", {31'd0, done}, 32'd1);
        check_now("running_at_budget", {31'd0, running}, 32'd0);
        bub = 1; f1 = 1; wb = 1;
        for (int i = 0; i < 5; i++) tick();
        events_off();
        read("budget_cycles", SEL_CYCLES);
        check_now("budget_cycles_const", data, 32'(MAXC));
        read("budget_stalls", SEL_STALLS);
        read("budget_flushes", SEL_FLUSHES);
        read("budget_retired", SEL_RETIRED);
        check_now("done_sticky", {31'd0, done}, 32'd1);
        start = 0;

        // Saturation on the 3-bit, unlimited-budget instance: 10 RUN cycles with wb_valid.
        start2 = 1; wb2 = 1; tick();
        for (int i = 0; i < 9; i++) tick();
        start2 = 0; tick();
        wb2 = 0;
        sel2 = SEL_RETIRED;
`ifdef PERF_RETIRE_EN
        push_exp("sat_retired", 32'd7);
`else
        push_exp("sat_retired", 32'd0);
`endif
        tick();
        pop_check({29'd0, data2});
        sel2 = SEL_CYCLES;
        push_exp("sat_cycles", 32'd7);
        tick();
        pop_check({29'd0, data2});
        check_now("sat_no_done", {31'd0, done2}, 32'd0);

        // Reset asserted mid-run discards counts immediately.
        clr = 1; tick(); clr = 0;
        start = 1; tick();
        sel = SEL_CYCLES;
        for (int i = 0; i < 3; i++) tick();
        check_now("midrun_before_rst", data, model_val(SEL_CYCLES) - 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_now("midrun_rst_data", data, 32'd0);
        check_now("midrun_rst_running", {31'd0, running}, 32'd0);
        start = 0;
        #1;
        rst_n = 1'b1;
        tick();
        read("post_rst_cycles", SEL_CYCLES);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
